// File: rtl/regfile_sb.sv
// regfile_sb: multi-ported register file with a per-register busy scoreboard.
// Register 0 is hardwired to zero and is never busy. An issue (alloc) marks a
// destination busy, and a writeback to it clears the busy bit again. flush
// clears every busy bit. busy_count is a registered popcount of the busy bits.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, a same-cycle
// writeback is forwarded to any read port whose address matches it.
module regfile_sb #(
  parameter  int XLEN     = 32,
  parameter  int NUM_REGS = 32,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WR   = 2,
  localparam int AW       = $clog2(NUM_REGS),
  localparam int CW       = $clog2(NUM_REGS + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_RD-1:0][AW-1:0]    rd_addr,
  output logic [NUM_RD-1:0][XLEN-1:0]  rd_data,
  output logic [NUM_RD-1:0]            rd_ready,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]    wr_addr,
  input  logic [NUM_WR-1:0][XLEN-1:0]  wr_data,
  input  logic                         alloc_en,
  input  logic [AW-1:0]                alloc_addr,
  output logic                         alloc_stall,
  input  logic                         flush,
  output logic [CW-1:0]                busy_count
);

  logic [XLEN-1:0]     r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [CW-1:0]       r_busy_count;

  logic [NUM_WR-1:0]   w_wr_valid;
  logic [NUM_REGS-1:0] w_wr_clr;
  logic                w_alloc_wr_hit;
  logic                w_alloc_req;
  logic                w_alloc_ok;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [CW-1:0]       w_count_nxt;

  // Qualify writes, find the registers they clear, and check for an alloc/write collision.
  // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_wr_valid     = '0;
    w_wr_clr       = '0;
    w_alloc_wr_hit = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      w_wr_valid[p] = wr_en[p] && (wr_addr[p] != '0);
      if (w_wr_valid[p]) begin
        w_wr_clr[wr_addr[p]] = 1'b1;
        if (wr_addr[p] == alloc_addr) w_alloc_wr_hit = 1'b1;
      end
    end
  end

  // Accept or refuse an allocation. A busy target is only accepted when a write clears it in the same cycle.
  always_comb begin
    w_alloc_req = alloc_en && (alloc_addr != '0);
    alloc_stall = w_alloc_req && r_busy[alloc_addr] && !w_alloc_wr_hit;
    w_alloc_ok  = w_alloc_req && !flush && (!r_busy[alloc_addr] || w_alloc_wr_hit);
  end

  // Next busy vector: flush clears everything, otherwise writes clear first and an alloc re-sets its bit on top.
  always_comb begin
    if (flush) begin
      w_busy_nxt = '0;
    end else begin
      w_busy_nxt = r_busy & ~w_wr_clr;
      if (w_alloc_ok) w_busy_nxt[alloc_addr] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Popcount of the next busy vector, so the registered count tracks the busy bits exactly.
  always_comb begin
    w_count_nxt = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_count_nxt = w_count_nxt + CW'(w_busy_nxt[r]);
    end
  end

  // Scoreboard state: busy bits and their count, updated together.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      r_busy       <= w_busy_nxt;
      r_busy_count <= w_count_nxt;
    end
  end

  // Register array: writes commit in port order, so the highest-index port wins on an address clash.
  // NOTE: the array is cleared on reset because the architecture requires all registers to read as zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (w_wr_valid[p]) r_regs[wr_addr[p]] <= wr_data[p];
      end
    end
  end

  // Read ports: array value and registered busy bit, optionally overridden by a matching same-cycle write.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data[i]  = (rd_addr[i] == '0) ? '0 : r_regs[rd_addr[i]];
      rd_ready[i] = !r_busy[rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NUM_WR; p++) begin
        if (w_wr_valid[p] && (wr_addr[p] == rd_addr[i])) begin
          rd_data[i]  = wr_data[p];
          rd_ready[i] = 1'b1;
        end
      end
`endif
    end
  end

  assign busy_count = r_busy_count;

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32: register data width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32: register count; AW = $clog2(NUM_REGS).
REQ-003 SHALL have parameter NUM_RD, default 2: number of read ports, range 1..4.
REQ-004 SHALL have parameter NUM_WR, default 2: number of write ports, range 1..4.
REQ-005 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port rd_addr, input, NUM_RD x AW bits: read port addresses.
REQ-008 SHALL have port rd_data, output, NUM_RD x XLEN bits: read data, combinational.
REQ-009 SHALL have port rd_ready, output, NUM_RD bits: operand valid, meaning no pending producer.
REQ-010 SHALL have port wr_en, input, NUM_WR bits: writeback strobe per port.
REQ-011 SHALL have port wr_addr, input, NUM_WR x AW bits: writeback destination.
REQ-012 SHALL have port wr_data, input, NUM_WR x XLEN bits: writeback value.
REQ-013 SHALL have port alloc_en, input, 1 bit: issue request that marks alloc_addr busy.
REQ-014 SHALL have port alloc_addr, input, AW bits: destination being issued.
REQ-015 SHALL have port alloc_stall, output, 1 bit: allocation refused (WAW hazard).
REQ-016 SHALL have port flush, input, 1 bit: clear all busy bits.
REQ-017 SHALL have port busy_count, output, $clog2(NUM_REGS+1) bits: registered count of busy registers.

Function
REQ-018 SHALL hardwire register 0: reads return 0, rd_ready=1, writes and allocations to it are ignored, and it is never busy.
REQ-019 SHALL commit wr_data[p] to register wr_addr[p] at the clock edge when wr_en[p]=1 and wr_addr[p]!=0.
REQ-020 SHALL resolve same-cycle writes to one address so that the highest-index write port wins.
REQ-021 SHALL clear the busy bit of every valid written address at the edge, unless REQ-023 applies.
REQ-022 SHALL set busy[alloc_addr] at the edge when alloc_en=1, alloc_addr!=0, busy[alloc_addr]=0 and flush=0.
REQ-023 SHALL leave the busy bit set when an allocation and a writeback target the same address in one cycle, because the new producer wins.
REQ-024 SHALL drive alloc_stall=1 combinationally when alloc_en=1, alloc_addr!=0, busy[alloc_addr]=1 and no same-cycle write clears it; a stalled allocation changes no state.
REQ-025 SHALL, on flush=1, clear all busy bits at the edge and ignore alloc_en that cycle, while writes still commit data.
REQ-026 SHALL drive rd_ready[i] = !busy[rd_addr[i]], except as extended by REQ-031.
REQ-027 SHALL update busy_count at the same edge as the busy bits so that it always equals popcount(busy).
REQ-028 SHALL allow a writeback to a non-busy register: data is written and busy stays 0.

Reset
REQ-029 SHALL, when reset=1 at a clock edge, clear registers 1..NUM_REGS-1 to 0, clear all busy bits and clear busy_count to 0.
REQ-030 SHALL give reset priority over flush, alloc and writes in the same cycle; outputs after reset are rd_data=0, rd_ready=all 1 and alloc_stall=0 when alloc_en=0.

Configuration
REQ-031 SHALL, with REGFILE_BYPASS_EN defined, forward a same-cycle valid write to a matching read port: rd_data takes the winning write's data and rd_ready=1.
REQ-032 SHALL, without REGFILE_BYPASS_EN, present the array value on rd_data with rd_ready from the registered busy bit only, so the new value is visible one cycle after the write.

Verification
REQ-033 SHALL cover: reset, then read x5 on both ports -> rd_data=0, rd_ready=1, busy_count=0.
REQ-034 SHALL cover: alloc x7, then next cycle read x7 -> rd_ready=0, busy_count=1; write x7=0xDEADBEEF -> bypass on: same cycle rd_data=0xDEADBEEF, rd_ready=1; bypass off: visible next cycle.
REQ-035 SHALL cover: x3 busy, alloc x3 -> alloc_stall=1, busy_count unchanged; same-cycle alloc x3 plus write x3 -> alloc accepted, x3 still busy.
REQ-036 SHALL cover: port0 writes x9=0x11 and port1 writes x9=0x22 in one cycle -> x9 reads 0x22.
REQ-037 SHALL cover: busy x1, x2, x4 (busy_count=3), then flush with alloc x6 -> busy_count=0, x6 not busy.
REQ-038 SHALL cover: write x0=0xFFFF_FFFF and alloc x0 -> x0 reads 0, rd_ready=1, busy_count=0.
